// File: rtl/grader_pkg.sv
// grader_pkg: shared types and constants for the grader arbiter slice.
//   arb_state_t : arbiter FSM state encoding
//   GUESS_W     : width of one question (four BCD-style digits)
//   SCORE_W     : width of strike / ball counts (0..4)
//   NIBBLE_W    : width of one digit inside a question
package grader_pkg;

  localparam int NIBBLE_W = 4;
  localparam int GUESS_W  = 4 * NIBBLE_W;
  localparam int SCORE_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_DELIVER  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational rotating-priority picker.
// Ports:
//   req     in  N_REQ  request vector
//   rr_ptr  in  IDX_W  index that currently has highest priority
//   grant   out N_REQ  one-hot grant (all zero when no request)
//   idx     out IDX_W  index of the granted bit
//   any_req out 1      at least one request is set
module rr_arbiter
  import grader_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any_req
);

  // Walk the rotated order from lowest priority to highest so that the
  // last hit, i.e. the one closest to rr_ptr, is the one that sticks.
  always_comb begin
    int pos;
    pos     = 0;
    grant   = '0;
    idx     = '0;
    any_req = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos = int'(rr_ptr) + k;
      if (pos >= N_REQ) pos = pos - N_REQ;
      if (req[pos]) begin
        grant      = '0;
        grant[pos] = 1'b1;
        idx        = IDX_W'(pos);
        any_req    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/grader_arbiter.sv
// grader_arbiter: shares one grader among N_REQ solver cores.
// Round-robin grant, drives the grader ask/reply handshakes for the granted
// core, returns strike/ball/correct on a shared response bus with a one-hot
// valid, and aborts with rsp_timeout after TIMEOUT cycles of grader stall.
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_question/req_ready   : per-core question side
//   rsp_valid/rsp_ready/rsp_*          : shared response bus, one-hot valid
//   g_question/g_ask_valid/g_reply_ready : question to grader
//   g_reply_valid/g_ask_ready/g_strike/g_ball/g_correct : result from grader
// Optional: define GRADER_ARB_STATS_EN to add per-core saturating counters
//   stat_queries / stat_solved (CNT_W bits per core, core i at [CNT_W*i +: CNT_W]).
module grader_arbiter
  import grader_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 200,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [GUESS_W*N_REQ-1:0] req_question,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_REQ-1:0]         rsp_valid,
  input  logic [N_REQ-1:0]         rsp_ready,
  output logic [SCORE_W-1:0]       rsp_strike,
  output logic [SCORE_W-1:0]       rsp_ball,
  output logic                     rsp_correct,
  output logic                     rsp_timeout,
  output logic [GUESS_W-1:0]       g_question,
  output logic                     g_ask_valid,
  input  logic                     g_reply_ready,
  input  logic                     g_reply_valid,
  output logic                     g_ask_ready,
  input  logic [SCORE_W-1:0]       g_strike,
  input  logic [SCORE_W-1:0]       g_ball,
  input  logic                     g_correct
`ifdef GRADER_ARB_STATS_EN
  ,
  output logic [CNT_W*N_REQ-1:0]   stat_queries,
  output logic [CNT_W*N_REQ-1:0]   stat_solved
`endif
);

  arb_state_t         state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant_idx;
  logic [N_REQ-1:0]   arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic [GUESS_W-1:0] q_lat;
  logic [SCORE_W-1:0] strike_r, ball_r;
  logic               correct_r, timeout_r;
  logic [CNT_W-1:0]   tmo_cnt;
  logic               expired;
  logic               accept;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req     (req_valid),
    .rr_ptr  (rr_ptr),
    .grant   (arb_grant),
    .idx     (arb_idx),
    .any_req (arb_any)
  );

  assign expired = (tmo_cnt >= CNT_W'(TIMEOUT - 1));
  assign accept  = (state == ST_DELIVER) && rsp_ready[grant_idx];

  assign g_question  = q_lat;
  assign rsp_strike  = strike_r;
  assign rsp_ball    = ball_r;
  assign rsp_correct = correct_r;
  assign rsp_timeout = timeout_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    req_ready   = '0;
    rsp_valid   = '0;
    g_ask_valid = 1'b0;
    g_ask_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        // The grant pulse is combinational, so mask it while reset is held
        // to keep every output quiet during reset.
        if (arb_any && reset) begin
          req_ready = arb_grant;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        g_ask_valid = 1'b1;
        // A handshake on the expiry cycle takes precedence over the abort.
        if (g_reply_ready)  state_nxt = ST_WAIT_RSP;
        else if (expired)   state_nxt = ST_DELIVER;
      end
      ST_WAIT_RSP: begin
        g_ask_ready = 1'b1;
        if (g_reply_valid || expired) state_nxt = ST_DELIVER;
      end
      ST_DELIVER: begin
        rsp_valid[grant_idx] = 1'b1;
        if (rsp_ready[grant_idx]) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr    <= '0;
      grant_idx <= '0;
      q_lat     <= '0;
      strike_r  <= '0;
      ball_r    <= '0;
      correct_r <= 1'b0;
      timeout_r <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            grant_idx <= arb_idx;
            q_lat     <= req_question[arb_idx*GUESS_W +: GUESS_W];
            tmo_cnt   <= '0;
          end
        end
        ST_ISSUE: begin
          tmo_cnt <= tmo_cnt + CNT_W'(1);
          if (!g_reply_ready && expired) begin
            strike_r  <= '0;
            ball_r    <= '0;
            correct_r <= 1'b0;
            timeout_r <= 1'b1;
          end
        end
        ST_WAIT_RSP: begin
          tmo_cnt <= tmo_cnt + CNT_W'(1);
          if (g_reply_valid) begin
            strike_r  <= g_strike;
            ball_r    <= g_ball;
            correct_r <= g_correct;
            timeout_r <= 1'b0;
          end else if (expired) begin
            strike_r  <= '0;
            ball_r    <= '0;
            correct_r <= 1'b0;
            timeout_r <= 1'b1;
          end
        end
        ST_DELIVER: begin
          if (accept) begin
            rr_ptr <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef GRADER_ARB_STATS_EN
  // Per-core counters, bumped once per accepted response and held at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_queries <= '0;
      stat_solved  <= '0;
    end else if (accept) begin
      if (stat_queries[grant_idx*CNT_W +: CNT_W] != {CNT_W{1'b1}})
        stat_queries[grant_idx*CNT_W +: CNT_W] <= stat_queries[grant_idx*CNT_W +: CNT_W] + CNT_W'(1);
      if (correct_r && (stat_solved[grant_idx*CNT_W +: CNT_W] != {CNT_W{1'b1}}))
        stat_solved[grant_idx*CNT_W +: CNT_W] <= stat_solved[grant_idx*CNT_W +: CNT_W] + CNT_W'(1);
    end
  end
`endif

endmodule

// File: doc/grader_arbiter.md
Name: grader_arbiter

Overview:
- Shares one grader instance among N_REQ solver cores.
- Round-robin arbitration over pending questions. Drives the grader's ask/reply handshake pair for the granted core and returns strike/ball/correct on a shared response bus with a one-hot valid.
- A timeout prevents a stalled grader from hanging the solvers.
- Sits between the solver array and the grader; the grader's answer input is driven elsewhere.

Parameters:
N_REQ, 4, number of requesters (2..8)
IDX_W, 2, width of requester index, equals clog2(N_REQ)
TIMEOUT, 200, cycles spent in ISSUE+WAIT_RSP before abort
CNT_W, 16, width of timeout and stats counters

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-core question pending
req_question  in  16*N_REQ  per-core guess, core i at [16*i+15:16*i], 4 BCD-style nibbles
req_ready  out  N_REQ  one-cycle one-hot grant pulse; question captured this cycle
rsp_valid  out  N_REQ  one-hot response valid, held until accepted
rsp_ready  in  N_REQ  per-core response accept
rsp_strike  out  3  strike count for current response
rsp_ball  out  3  ball count for current response
rsp_correct  out  1  all four digits matched
rsp_timeout  out  1  response is an abort, scores forced 0
g_question  out  16  question to grader
g_ask_valid  out  1  question valid to grader
g_reply_ready  in  1  grader accepts question
g_reply_valid  in  1  grader result valid
g_ask_ready  out  1  arbiter accepts grader result
g_strike  in  3  grader strike
g_ball  in  3  grader ball
g_correct  in  1  grader correct

Behaviour:
- Reset: all outputs 0, state IDLE, rr_ptr=0, timeout counter 0, captured question and scores 0. Reset asserted mid-transaction aborts immediately and produces no response.
- FSM states: IDLE, ISSUE, WAIT_RSP, DELIVER.
- IDLE:
  - If any req_valid, pick the first set bit searching from rr_ptr upward with wrap.
  - Pulse req_ready[grant]=1 for that cycle, latch question and grant index, go to ISSUE.
  - Grant decision is combinational from registered rr_ptr.
- ISSUE:
  - g_ask_valid=1, g_question=latched value, g_ask_ready=0.
  - On g_ask_valid & g_reply_ready, go to WAIT_RSP; g_ask_valid drops the next cycle.
- WAIT_RSP:
  - g_ask_ready=1.
  - On g_reply_valid, capture g_strike/g_ball/g_correct, set rsp_timeout=0, go to DELIVER.
- DELIVER:
  - rsp_valid[grant]=1; rsp_* stable until rsp_ready[grant].
  - On accept: rr_ptr <= (grant+1) mod N_REQ, go to IDLE.
  - No new grant in the accept cycle; minimum 1 IDLE cycle between transactions.
- Timeout:
  - Counter clears on entry to ISSUE and increments each cycle in ISSUE/WAIT_RSP.
  - When it reaches TIMEOUT-1 without the pending handshake, go to DELIVER with rsp_timeout=1 and strike=ball=correct=0.
  - g_ask_valid/g_ask_ready drop.
  - A handshake in the same cycle as expiry wins over timeout.
- Latency with the standard grader (reply_ready registered from ask_valid):
  - req_ready pulse at cycle 0, ISSUE at cycle 1, handshake at cycle 2, reply_valid at cycle 3, rsp_valid at cycle 4.
- Simultaneous events:
  - req_valid deasserting after grant has no effect.
  - Non-granted requesters keep waiting; req_question must be held while req_valid=1.
  - rsp_ready on non-granted bits is ignored.
- Fairness: a requester waits at most N_REQ-1 transactions.

Optional Feature:
- Macro GRADER_ARB_STATS_EN.
- Defined: adds outputs stat_queries (CNT_W*N_REQ) and stat_solved (CNT_W*N_REQ).
  - Per-core counters increment on rsp accept.
  - stat_solved increments only when rsp_correct=1.
  - Counters saturate at all-ones and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package grader_pkg: FSM state encoding, GUESS_W=16, SCORE_W=3, NIBBLE_W=4.
- Sub-module rr_arbiter: inputs req vector and rr_ptr; outputs one-hot grant, index and any_req. Purely combinational priority rotate, reused by later multi-core blocks.

Test Plan:
- Single core 0, question 0x1234, grader answer 0x1234: req_ready at c0, rsp_valid=0001 at c4, strike=4, ball=0, correct=1.
- Question 0x4321 vs answer 0x1234: strike=0, ball=4, correct=0. Question 0x1243: strike=2, ball=2.
- All four req_valid held continuously: grants 0,1,2,3,0 in order; rsp_ready held low 5 cycles on core 1 stalls the arbiter with no other grant issued.
- Grader model holds reply_ready=0: after TIMEOUT=200 cycles, rsp_valid with rsp_timeout=1 and scores 0; next request served normally.
- reset pulled low during WAIT_RSP: all outputs 0 asynchronously, no rsp_valid after release, rr_ptr=0.
- With GRADER_ARB_STATS_EN: 3 queries from core 2, 1 correct: stat_queries[2]=3, stat_solved[2]=1, others 0.
